fc_output_drain: RTL and testbench
==================================

Name: fc_output_drain

Overview:
- Downstream stage of the fully-connected controller.
- On each `set_output` pulse it captures the TILING_SIZE parallel partial sums of the finished tile into a two-entry ping-pong buffer.
- Each lane is post-processed: rescale, optional ReLU, saturate.
- The tile is then serialized onto a valid/ready output-feature-map stream with a global neuron index.
- It raises `tile_full` so the controller can stall the next tile, and flags `done` after the final neuron of the layer.

Parameters:
- TILING_SIZE, 8: lanes per tile; one partial sum per PE.
- KERNEL_SIZE, 4096: total output neurons in the layer.
- PSUM_W, 32: signed partial-sum width per lane.
- OUT_W, 16: signed output width.
- FRAC_SHIFT, 8: arithmetic right shift applied before saturation.
- RELU_EN, 1: 1 clamps negative results to 0.

Ports:
- clk1, input, 1: single clock; all logic on its rising edge.
- rst_n, input, 1: synchronous, active-high reset. Sampled on the clk1 rising edge; 1 = reset.
- set_output, input, 1: one-cycle pulse; the current psum_in vector is a completed tile.
- counter_tiling, input, 16: controller tile counter at the pulse; the completed tile index is counter_tiling-1.
- psum_in, input, TILING_SIZE*PSUM_W: lane k is at bits [k*PSUM_W +: PSUM_W].
- ofm_ready, input, 1: consumer accepts ofm_data this cycle.
- ofm_valid, output, 1: ofm_data/ofm_index/ofm_last are valid.
- ofm_data, output, OUT_W: post-processed neuron value.
- ofm_index, output, 16: global neuron index, tile_idx*TILING_SIZE + lane.
- ofm_last, output, 1: high with the element whose ofm_index == KERNEL_SIZE-1.
- tile_full, output, 1: both buffer entries occupied.
- overflow_err, output, 1: sticky; a set_output pulse arrived while tile_full.
- done, output, 1: sticky; the last element has been accepted.

Behaviour:
- Reset (rst_n=1 at a clock edge) forces:
  - ofm_valid=0, ofm_data=0, ofm_index=0, ofm_last=0
  - tile_full=0, overflow_err=0, done=0
  - both entries empty, write/read pointers 0, lane counter 0, FSM=IDLE.
- Reset mid-drain discards all buffered tiles; there is no partial completion.
- Capture:
  - On set_output=1 with fewer than 2 entries occupied, write psum_in and tile_idx=counter_tiling-1 into entry[wr_ptr].
  - Toggle wr_ptr and increment the occupancy count.
  - If set_output=1 while counter_tiling==0, ignore the pulse; no capture.
  - If set_output=1 while tile_full=1, drop the tile, set overflow_err, and leave buffer state unchanged.
- Post-process per lane, combinational on read:
  - t = psum >>> FRAC_SHIFT (sign-preserving).
  - If RELU_EN and t<0, t=0.
  - Saturate t to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- FSM states:
  - IDLE:
    - Go to DRAIN when occupancy>0.
    - Lane counter = 0.
  - DRAIN:
    - ofm_valid=1 with lane[lane_cnt] of entry[rd_ptr].
    - A handshake (ofm_valid & ofm_ready) advances lane_cnt.
    - Handshake on lane TILING_SIZE-1: toggle rd_ptr, decrement occupancy, reset lane_cnt.
      - If that element had ofm_last=1, go to DONE.
      - Else if another entry is occupied (including one captured the same cycle), stay in DRAIN with no bubble.
      - Else go to IDLE.
  - DONE:
    - done=1, ofm_valid=0.
    - Further set_output pulses are ignored and do not set overflow_err.
    - Leave DONE only by reset.
- Output registers:
  - ofm_data/ofm_index/ofm_last are registered.
  - First valid element appears 2 cycles after the capturing set_output edge when the buffer was empty: capture edge, then load edge.
  - While ofm_valid=1 and ofm_ready=0, outputs hold stable.
- Simultaneous events:
  - Capture and release of the final lane in the same cycle: the occupancy count is unchanged and tile_full is updated consistently.
  - A capture in the same cycle that full clears is accepted, because the release is evaluated first.
- Widths:
  - ofm_index is computed modulo 2^16.
  - KERNEL_SIZE must be a multiple of TILING_SIZE and ≤ 65536.
  - The final tile index is KERNEL_SIZE/TILING_SIZE-1.

Test Plan:
1. Single tile, lanes holding 0x00000100*(k+1), counter_tiling=1, ofm_ready=1: 8 outputs, data 1..8, index 0..7, ofm_valid high for 8 consecutive cycles starting 2 cycles after the pulse.
2. Arithmetic:
   - RELU_EN=1: lanes {-256, 0x7FFFFFFF, 0x80000000, 255} → {0, 32767, 0, 0}.
   - RELU_EN=0: same lanes → {-1, 32767, -32768, 0}.
3. Backpressure: ofm_ready toggles 1,0,0,1…; data and index hold while stalled; no element is lost or duplicated; order is 0..7.
4. Ping-pong:
   - Three pulses (tiles 0,1,2) 3 cycles apart with ofm_ready=0: tile_full=1 after the second pulse; the third pulse sets overflow_err.
   - Releasing ready then drains indices 0..15 with no bubble between tiles.
5. Full layer, KERNEL_SIZE=16, TILING_SIZE=8: tiles 0 and 1; ofm_last=1 only at index 15; done=1 the cycle after that handshake; a later set_output is ignored.
6. Reset (rst_n=1 for 1 cycle) mid-drain at lane 3 of tile 0: all outputs return to reset values the next cycle; a new tile drains from lane 0.

Source files
------------

// File: rtl/fc_output_drain_if.sv
// Output-feature-map stream: one post-processed neuron per handshake,
// tagged with its global index and an end-of-layer marker.
interface fc_output_drain_if #(
    parameter int OUT_W = 16
) ();
    logic             ofm_valid;
    logic             ofm_ready;
    logic [OUT_W-1:0] ofm_data;
    logic [15:0]      ofm_index;
    logic             ofm_last;

    modport master (
        output ofm_valid,
        output ofm_data,
        output ofm_index,
        output ofm_last,
        input  ofm_ready
    );

    modport slave (
        input  ofm_valid,
        input  ofm_data,
        input  ofm_index,
        input  ofm_last,
        output ofm_ready
    );
endinterface

// File: rtl/fc_output_drain.sv
// Captures finished FC tiles into a ping-pong buffer, rescales/ReLUs/saturates
// each lane and serializes the tile onto the OFM stream with global indices.
module fc_output_drain #(
    parameter int TILING_SIZE = 8,
    parameter int KERNEL_SIZE = 4096,
    parameter int PSUM_W      = 32,
    parameter int OUT_W       = 16,
    parameter int FRAC_SHIFT  = 8,
    parameter int RELU_EN     = 1
) (
    input  logic                          clk1,
    input  logic                          rst_n,
    input  logic                          set_output,
    input  logic [15:0]                   counter_tiling,
    input  logic [TILING_SIZE*PSUM_W-1:0] psum_in,
    fc_output_drain_if.master             ofm,
    output logic                          tile_full,
    output logic                          overflow_err,
    output logic                          done
);
    localparam int LANE_W = (TILING_SIZE > 1) ? $clog2(TILING_SIZE) : 1;
    localparam logic [15:0] LAST_IDX = 16'(KERNEL_SIZE - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(TILING_SIZE - 1);
    localparam logic signed [PSUM_W-1:0] SAT_MAX =
        {{(PSUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] SAT_MIN =
        {{(PSUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t                          state_reg;
    logic [TILING_SIZE*PSUM_W-1:0]   buf_psum [2];
    logic [15:0]                     buf_tile [2];
    logic                            wr_ptr_reg;
    logic                            rd_ptr_reg;
    logic [1:0]                      occ_reg;
    logic [LANE_W-1:0]               lane_cnt_reg;
    logic                            valid_reg;
    logic [OUT_W-1:0]                data_reg;
    logic [15:0]                     index_reg;
    logic                            last_reg;
    logic                            overflow_reg;
    logic                            done_reg;

    function automatic logic [OUT_W-1:0] post_proc(input logic signed [PSUM_W-1:0] p);
        logic signed [PSUM_W-1:0] t;
        t = p >>> FRAC_SHIFT;
        if (RELU_EN != 0 && t[PSUM_W-1]) t = '0;
        if (t > SAT_MAX)      t = SAT_MAX;
        else if (t < SAT_MIN) t = SAT_MIN;
        return t[OUT_W-1:0];
    endfunction

    function automatic logic [15:0] neuron_idx(input logic [15:0] tile, input logic [LANE_W-1:0] lane);
        return tile * 16'(TILING_SIZE) + 16'(lane);
    endfunction

    // Lanes of the entry currently being drained, already post-processed.
    logic [TILING_SIZE*PSUM_W-1:0] cur_vec;
    logic [OUT_W-1:0]              pp_cur [TILING_SIZE];
    assign cur_vec = buf_psum[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < TILING_SIZE; gi++) begin : g_lane
            assign pp_cur[gi] = post_proc(cur_vec[gi*PSUM_W +: PSUM_W]);
        end
    endgenerate

    // Next tile after a release: the other entry if already held, otherwise
    // the tile being captured this very cycle (bypass keeps the stream gapless).
    logic [TILING_SIZE*PSUM_W-1:0] nxt_vec;
    logic [15:0]                   nxt_tile;
    logic [OUT_W-1:0]              pp_nxt0;
    assign nxt_vec  = (occ_reg == 2'd2) ? buf_psum[~rd_ptr_reg] : psum_in;
    assign nxt_tile = (occ_reg == 2'd2) ? buf_tile[~rd_ptr_reg] : counter_tiling - 16'd1;
    assign pp_nxt0  = post_proc(nxt_vec[PSUM_W-1:0]);

    logic              capture_req, capture, overflow_evt, handshake, release_ent;
    logic [1:0]        occ_after_rel, occ_next;
    logic [LANE_W-1:0] lane_inc;
    logic [15:0]       cur_idx_inc, nxt_idx0, cur_idx0;

    always_comb begin
        capture_req   = set_output && (counter_tiling != 16'd0) && (state_reg != DONE);
        handshake     = valid_reg && ofm.ofm_ready;
        release_ent   = handshake && (state_reg == DRAIN) && (lane_cnt_reg == LAST_LANE);
        // Release is accounted before the capture decision, so a full buffer
        // draining its last lane can still take a new tile.
        occ_after_rel = occ_reg - {1'b0, release_ent};
        capture       = capture_req && (occ_after_rel != 2'd2);
        overflow_evt  = capture_req && !capture;
        occ_next      = occ_after_rel + {1'b0, capture};
        lane_inc      = lane_cnt_reg + LANE_W'(1);
        cur_idx0      = neuron_idx(buf_tile[rd_ptr_reg], '0);
        cur_idx_inc   = neuron_idx(buf_tile[rd_ptr_reg], lane_inc);
        nxt_idx0      = neuron_idx(nxt_tile, '0);
    end

    always_ff @(posedge clk1) begin
        if (rst_n) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            occ_reg      <= 2'd0;
            lane_cnt_reg <= '0;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            index_reg    <= '0;
            last_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            if (capture) begin
                buf_psum[wr_ptr_reg] <= psum_in;
                buf_tile[wr_ptr_reg] <= counter_tiling - 16'd1;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            occ_reg <= occ_next;
            if (overflow_evt) overflow_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    lane_cnt_reg <= '0;
                    if (occ_reg != 2'd0) begin
                        valid_reg <= 1'b1;
                        data_reg  <= pp_cur[0];
                        index_reg <= cur_idx0;
                        last_reg  <= (cur_idx0 == LAST_IDX);
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        if (lane_cnt_reg == LAST_LANE) begin
                            rd_ptr_reg   <= ~rd_ptr_reg;
                            lane_cnt_reg <= '0;
                            if (last_reg) begin
                                valid_reg <= 1'b0;
                                done_reg  <= 1'b1;
                                state_reg <= DONE;
                            end else if (occ_reg == 2'd2 || capture) begin
                                data_reg  <= pp_nxt0;
                                index_reg <= nxt_idx0;
                                last_reg  <= (nxt_idx0 == LAST_IDX);
                            end else begin
                                valid_reg <= 1'b0;
                                state_reg <= IDLE;
                            end
                        end else begin
                            lane_cnt_reg <= lane_inc;
                            data_reg     <= pp_cur[lane_inc];
                            index_reg    <= cur_idx_inc;
                            last_reg     <= (cur_idx_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ofm.ofm_valid = valid_reg;
    assign ofm.ofm_data  = data_reg;
    assign ofm.ofm_index = index_reg;
    assign ofm.ofm_last  = last_reg;
    assign tile_full     = (occ_reg == 2'd2);
    assign overflow_err  = overflow_reg;
    assign done          = done_reg;
endmodule

// File: tb/tb_fc_output_drain.sv
// Directed bench: two drains share stimulus, one with ReLU and a 16-neuron
// layer, one without ReLU and the default 4096-neuron layer.
module tb_fc_output_drain;
    logic         clk1;
    logic         rst_n;
    logic         set_output;
    logic [15:0]  counter_tiling;
    logic [255:0] psum;
    logic         ready;
    logic         full_a, ovf_a, done_a, full_b, ovf_b, done_b;

    int check_cnt;
    int err_cnt;

    logic [15:0] got_data [32];
    logic [15:0] got_idx  [32];
    logic        got_last [32];
    int          got_cyc  [32];
    int          got_n;

    fc_output_drain_if #(.OUT_W(16)) ofm_a ();
    fc_output_drain_if #(.OUT_W(16)) ofm_b ();
    assign ofm_a.ofm_ready = ready;
    assign ofm_b.ofm_ready = ready;

    fc_output_drain #(.TILING_SIZE(8), .KERNEL_SIZE(16), .PSUM_W(32), .OUT_W(16),
                      .FRAC_SHIFT(8), .RELU_EN(1)) dut_a (
        .clk1(clk1), .rst_n(rst_n), .set_output(set_output), .counter_tiling(counter_tiling),
        .psum_in(psum), .ofm(ofm_a), .tile_full(full_a), .overflow_err(ovf_a), .done(done_a));

    fc_output_drain #(.TILING_SIZE(8), .KERNEL_SIZE(4096), .PSUM_W(32), .OUT_W(16),
                      .FRAC_SHIFT(8), .RELU_EN(0)) dut_b (
        .clk1(clk1), .rst_n(rst_n), .set_output(set_output), .counter_tiling(counter_tiling),
        .psum_in(psum), .ofm(ofm_b), .tile_full(full_b), .overflow_err(ovf_b), .done(done_b));

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1; set_output = 1'b0; ready = 1'b0; counter_tiling = '0;
        tick(); tick();
        rst_n = 1'b0;
    endtask

    task automatic load_ramp(input int base);
        for (int k = 0; k < 8; k++) psum[k*32 +: 32] = 32'((base + k) << 8);
    endtask

    task automatic pulse(input int ctr);
        set_output = 1'b1;
        counter_tiling = 16'(ctr);
        tick();
        set_output = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready high every third cycle
    task automatic collect(input int n, input int mode, input int budget);
        logic pv, pr;
        logic [15:0] pd, pi;
        got_n = 0; pv = 1'b0; pr = 1'b1; pd = '0; pi = '0;
        for (int cyc = 0; cyc < budget && got_n < n; cyc++) begin
            ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (pv && !pr) begin
                check("hold_valid", 32'(ofm_a.ofm_valid), 32'd1);
                check("hold_data", 32'(ofm_a.ofm_data), 32'(pd));
                check("hold_index", 32'(ofm_a.ofm_index), 32'(pi));
            end
            if (ofm_a.ofm_valid && ready) begin
                got_data[got_n] = ofm_a.ofm_data;
                got_idx[got_n]  = ofm_a.ofm_index;
                got_last[got_n] = ofm_a.ofm_last;
                got_cyc[got_n]  = cyc;
                got_n++;
                $display("accept idx=%0d data=%0d last=%0d cyc=%0d",
                         ofm_a.ofm_index, ofm_a.ofm_data, ofm_a.ofm_last, cyc);
            end
            pv = ofm_a.ofm_valid; pr = ready; pd = ofm_a.ofm_data; pi = ofm_a.ofm_index;
            tick();
        end
        check("collect_count", 32'(got_n), 32'(n));
    endtask

    initial begin
        logic [15:0] exp_a [4];
        logic [15:0] exp_b [4];
        check_cnt = 0; err_cnt = 0;
        psum = '0;
        do_reset();

        // Reset state
        check("rst_valid", 32'(ofm_a.ofm_valid), 32'd0);
        check("rst_data", 32'(ofm_a.ofm_data), 32'd0);
        check("rst_index", 32'(ofm_a.ofm_index), 32'd0);
        check("rst_last", 32'(ofm_a.ofm_last), 32'd0);
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);

        // Test 1: single tile, latency and back-to-back lanes
        load_ramp(1);
        ready = 1'b1;
        pulse(1);
        check("t1_lat_valid", 32'(ofm_a.ofm_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t1_valid", 32'(ofm_a.ofm_valid), 32'd1);
            check("t1_data", 32'(ofm_a.ofm_data), 32'(k + 1));
            check("t1_index", 32'(ofm_a.ofm_index), 32'(k));
            $display("t1 lane=%0d data=%0d index=%0d", k, ofm_a.ofm_data, ofm_a.ofm_index);
        end
        tick();
        check("t1_end_valid", 32'(ofm_a.ofm_valid), 32'd0);

        // Test 2: rescale / ReLU / saturation
        do_reset();
        psum = '0;
        psum[0*32 +: 32] = 32'hFFFFFF00;
        psum[1*32 +: 32] = 32'h7FFFFFFF;
        psum[2*32 +: 32] = 32'h80000000;
        psum[3*32 +: 32] = 32'h000000FF;
        exp_a = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
        exp_b = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
        ready = 1'b1;
        pulse(1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_relu", 32'(ofm_a.ofm_data), 32'(exp_a[k]));
            check("t2_norelu", 32'(ofm_b.ofm_data), 32'(exp_b[k]));
            $display("t2 lane=%0d relu=%0h norelu=%0h", k, ofm_a.ofm_data, ofm_b.ofm_data);
        end
        for (int k = 0; k < 6; k++) tick();

        // Test 3: backpressure
        do_reset();
        load_ramp(10);
        pulse(1);
        collect(8, 1, 100);
        for (int k = 0; k < 8; k++) begin
            check("t3_index", 32'(got_idx[k]), 32'(k));
            check("t3_data", 32'(got_data[k]), 32'(10 + k));
        end

        // Test 4: ping-pong fill, overflow, gapless drain
        do_reset();
        load_ramp(1);
        pulse(1);
        tick(); tick();
        check("t4_full_one", 32'(full_a), 32'd0);
        load_ramp(20);
        pulse(2);
        check("t4_full_two", 32'(full_a), 32'd1);
        tick(); tick();
        load_ramp(40);
        pulse(3);
        check("t4_ovf", 32'(ovf_a), 32'd1);
        check("t4_full_kept", 32'(full_a), 32'd1);
        collect(16, 0, 40);
        for (int k = 0; k < 16; k++) begin
            check("t4_index", 32'(got_idx[k]), 32'(k));
            check("t4_data", 32'(got_data[k]), (k < 8) ? 32'(k + 1) : 32'(12 + k));
            check("t4_nobubble", 32'(got_cyc[k] - got_cyc[0]), 32'(k));
        end

        // Test 5: full layer, last flag, done, later pulses ignored
        do_reset();
        load_ramp(1);
        pulse(1);
        tick();
        load_ramp(20);
        pulse(2);
        collect(16, 0, 40);
        for (int k = 0; k < 16; k++) begin
            check("t5_last", 32'(got_last[k]), (k == 15) ? 32'd1 : 32'd0);
        end
        check("t5_done", 32'(done_a), 32'd1);
        check("t5_valid_off", 32'(ofm_a.ofm_valid), 32'd0);
        ready = 1'b0;
        pulse(1);
        pulse(2);
        pulse(3);
        tick(); tick();
        check("t5_ovf_ignored", 32'(ovf_a), 32'd0);
        check("t5_done_sticky", 32'(done_a), 32'd1);
        check("t5_valid_done", 32'(ofm_a.ofm_valid), 32'd0);
        check("t5_full_done", 32'(full_a), 32'd0);

        // Test 6: reset mid-drain
        do_reset();
        load_ramp(1);
        ready = 1'b1;
        pulse(1);
        tick(); tick(); tick(); tick();
        check("t6_at_lane3", 32'(ofm_a.ofm_index), 32'd3);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("t6_rst_valid", 32'(ofm_a.ofm_valid), 32'd0);
        check("t6_rst_data", 32'(ofm_a.ofm_data), 32'd0);
        check("t6_rst_index", 32'(ofm_a.ofm_index), 32'd0);
        check("t6_rst_full", 32'(full_a), 32'd0);
        ready = 1'b0;
        load_ramp(30);
        pulse(1);
        collect(8, 0, 30);
        for (int k = 0; k < 8; k++) begin
            check("t6_index", 32'(got_idx[k]), 32'(k));
            check("t6_data", 32'(got_data[k]), 32'(30 + k));
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end
endmodule
